// File: rtl/rotating_priority_encoder.sv
// Rotating priority encoder: picks the first set request starting at
// start_index and wrapping modulo SIZE, so the channel just before
// start_index is considered last.
module rotating_priority_encoder #(
    parameter int SIZE = 4,
    localparam int INDEX_WIDTH = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]        requests,
    input  logic [INDEX_WIDTH-1:0] start_index,
    output logic [SIZE-1:0]        grant,
    output logic [INDEX_WIDTH-1:0] grant_index
);

    // Walk the channels in wrapped order and keep the first hit.
    always_comb begin
        logic found;
        int   idx;
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        idx         = 0;
        for (int i = 0; i < SIZE; i++) begin
            idx = (int'(start_index) + i) % SIZE;
            if (!found && requests[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_index = INDEX_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: the owner keeps the grant for up to its
// effective weight in consecutive cycles; otherwise the next requester after
// the owner wins. Weight 0 behaves as weight 1.
module weighted_round_robin_arbiter #(
    parameter int SIZE = 4,
    parameter int WEIGHT_WIDTH = 4,
    localparam int INDEX_WIDTH = $clog2(SIZE)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE-1:0]              requests,
    input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
    output logic [SIZE-1:0]              grant,
    output logic [INDEX_WIDTH-1:0]       grant_index,
    output logic                         locked
);

    logic [INDEX_WIDTH-1:0]                  owner_index;
    logic                                    owner_valid;
    logic [WEIGHT_WIDTH-1:0]                 used_count;
    // Effective weight of the owner, captured when its burst starts so later
    // weight changes cannot stretch or cut the running burst.
    logic [WEIGHT_WIDTH-1:0]                 owner_weight;

    logic [SIZE-1:0][WEIGHT_WIDTH-1:0]       eff_weight;
    logic [INDEX_WIDTH-1:0]                  start_index;
    logic [SIZE-1:0]                         search_grant;
    logic [INDEX_WIDTH-1:0]                  search_index;
    logic                                    owner_hit;
    logic [WEIGHT_WIDTH:0]                   used_next;

    // Per-channel effective weight: zero is promoted to one.
    for (genvar g = 0; g < SIZE; g++) begin : g_eff
        assign eff_weight[g] = (weights[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                             ? WEIGHT_WIDTH'(1)
                             : weights[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    // Search starts just past the owner so the owner itself is tried last.
    assign start_index = (owner_index == INDEX_WIDTH'(SIZE-1))
                       ? '0 : owner_index + INDEX_WIDTH'(1);

    rotating_priority_encoder #(.SIZE(SIZE)) u_search (
        .requests    (requests),
        .start_index (start_index),
        .grant       (search_grant),
        .grant_index (search_index)
    );

    assign owner_hit = owner_valid && requests[owner_index];
    assign used_next = {1'b0, used_count} + (WEIGHT_WIDTH+1)'(1);
    assign locked    = owner_valid;

    // Owner with credit keeps the grant; otherwise the wrapped search decides.
    always_comb begin
        if (owner_hit) begin
            grant       = SIZE'(1) << owner_index;
            grant_index = owner_index;
        end else begin
            grant       = search_grant;
            grant_index = search_index;
        end
    end

    // Ownership and credit bookkeeping; reset overrides any burst in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_index  <= INDEX_WIDTH'(SIZE-1);
            owner_valid  <= 1'b0;
            used_count   <= '0;
            owner_weight <= '0;
        end else if (requests == '0) begin
            owner_valid  <= 1'b0;
        end else if (owner_hit) begin
            used_count   <= used_next[WEIGHT_WIDTH-1:0];
            if (used_next == {1'b0, owner_weight})
                owner_valid <= 1'b0;
        end else begin
            // A new burst (also covers the old owner re-winning after its
            // credit ran out or after it dropped its request).
            owner_index  <= search_index;
            used_count   <= WEIGHT_WIDTH'(1);
            owner_weight <= eff_weight[search_index];
            owner_valid  <= (eff_weight[search_index] > WEIGHT_WIDTH'(1));
        end
    end

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Bench for weighted_round_robin_arbiter (SIZE=4, WEIGHT_WIDTH=4): directed
// scenarios plus randomized traffic against a credit-counting reference model.
module tb_weighted_round_robin_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  requests;
    logic [15:0] weights;
    logic [3:0]  grant;
    logic [1:0]  grant_index;
    logic        locked;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the channel and how many grants it may still take.
    int m_owner  = 3;
    int m_credit = 0;
    bit m_init   = 0;

    logic [3:0] last_grant;
    int         last_idx;
    logic       last_locked;
    int         wait_cnt [4];

    weighted_round_robin_arbiter #(.SIZE(4), .WEIGHT_WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .requests    (requests),
        .weights     (weights),
        .grant       (grant),
        .grant_index (grant_index),
        .locked      (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int eff(input logic [15:0] w, input int c);
        int v;
        v = int'(w[c*4 +: 4]);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance it.
    task automatic do_cycle(input logic rst, input logic [3:0] r, input logic [15:0] w);
        int         eg;
        int         c;
        logic [3:0] eg_vec;
        @(negedge clock);
        reset    = rst;
        requests = r;
        weights  = w;
        #1;
        eg = -1;
        if (m_credit > 0 && r[m_owner]) eg = m_owner;
        else begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_owner + k) % 4;
                if (eg < 0 && r[c]) eg = c;
            end
        end
        eg_vec = (eg < 0) ? 4'b0000 : (4'b0001 << eg);
        if (m_init) begin
            chk("model_grant", 32'(grant), 32'(eg_vec));
            chk("model_index", 32'(grant_index), (eg < 0) ? 32'd0 : 32'(eg));
            chk("model_locked", 32'(locked), 32'(m_credit > 0));
        end
        last_grant  = grant;
        last_idx    = int'(grant_index);
        last_locked = locked;
        if (rst) begin
            m_owner  = 3;
            m_credit = 0;
            m_init   = 1;
        end else if (eg < 0) begin
            m_credit = 0;
        end else if (eg == m_owner && m_credit > 0) begin
            m_credit--;
        end else begin
            m_owner  = eg;
            m_credit = eff(w, eg) - 1;
        end
    endtask

    initial begin
        int          exp_seq [10];
        logic [3:0]  r;
        logic [15:0] w;
        int          bound;

        reset    = 1'b1;
        requests = '0;
        weights  = '0;

        // Reset state: nothing granted, channel 0 first in line.
        do_cycle(1'b1, 4'b0000, 16'h0000);
        do_cycle(1'b0, 4'b0000, 16'h0000);
        chk("reset_grant_zero", 32'(last_grant), 32'd0);
        chk("reset_index_zero", 32'(last_idx), 32'd0);
        chk("reset_locked", 32'(last_locked), 32'd0);

        // Weights {4,3,2,1} on channels 3..0, all requesting.
        exp_seq = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        do_cycle(1'b1, 4'b1111, 16'h4321);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b0, 4'b1111, 16'h4321);
            chk("weighted_seq", 32'(last_idx), 32'(exp_seq[i % 10]));
        end

        // Lone channel 2 with weight 3: granted every cycle, locked 1,1,0.
        do_cycle(1'b1, 4'b0000, 16'h0300);
        for (int k = 0; k < 9; k++) begin
            do_cycle(1'b0, 4'b0100, 16'h0300);
            chk("lone_grant", 32'(last_grant), 32'h4);
            if (k >= 1) chk("lone_locked", 32'(last_locked), 32'((k - 1) % 3 != 2));
        end

        // All weights zero: plain round robin, never locked.
        do_cycle(1'b1, 4'b0000, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 4'b1111, 16'h0000);
            chk("rr_index", 32'(last_idx), 32'(i % 4));
            chk("rr_locked", 32'(last_locked), 32'd0);
        end

        // Channel 1 (weight 4) drops after two grants, then re-requests.
        do_cycle(1'b1, 4'b0000, 16'h1141);
        do_cycle(1'b0, 4'b0010, 16'h1141);
        do_cycle(1'b0, 4'b0010, 16'h1141);
        chk("drop_pre_locked", 32'(last_locked), 32'd1);
        do_cycle(1'b0, 4'b1101, 16'h1141);
        chk("drop_next_owner", 32'(last_idx), 32'd2);
        exp_seq = '{3, 0, 1, 1, 1, 1, 2, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            do_cycle(1'b0, 4'b1111, 16'h1141);
            chk("drop_fresh_burst", 32'(last_idx), 32'(exp_seq[i]));
        end

        // Reset in the middle of channel 2's burst.
        do_cycle(1'b1, 4'b0000, 16'h4444);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 4'b1111, 16'h4444);
        chk("midburst_owner", 32'(last_idx), 32'd2);
        do_cycle(1'b1, 4'b1111, 16'h4444);
        do_cycle(1'b0, 4'b1111, 16'h4444);
        chk("post_reset_grant", 32'(last_idx), 32'd0);

        // Random traffic, weights fixed per segment (segment starts idle).
        r = 4'b0000;
        for (int s = 0; s < 5; s++) begin
            w = 16'($urandom());
            do_cycle(1'b0, 4'b0000, w);
            for (int c = 0; c < 4; c++) wait_cnt[c] = 0;
            for (int n = 0; n < 200; n++) begin
                r = r ^ (4'($urandom()) & 4'($urandom()));
                do_cycle(1'b0, r, w);
                chk("onehot_or_zero", 32'($onehot0(last_grant)), 32'd1);
                chk("grant_implies_req", 32'(last_grant & ~r), 32'd0);
                chk("req_implies_grant", 32'($countones(last_grant)), 32'(r != 4'b0000));
                for (int c = 0; c < 4; c++) begin
                    if (r[c] && !last_grant[c]) wait_cnt[c]++;
                    else wait_cnt[c] = 0;
                    bound = 0;
                    for (int j = 0; j < 4; j++) if (j != c) bound += eff(w, j);
                    chk("wait_bound", 32'(wait_cnt[c] <= bound), 32'd1);
                end
            end
        end

        // Weights changing every cycle: bursts must keep their sampled weight.
        for (int n = 0; n < 200; n++) begin
            r = r ^ (4'($urandom()) & 4'($urandom()));
            do_cycle(n == 100, r, 16'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
